// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands and opcode in, registered result and flags out.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;
    logic             flag_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out_result, flag_z, flag_c, flag_n, flag_v, flag_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out_result, flag_z, flag_c, flag_n, flag_v, flag_err
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative shifts, registered result and flags.
// Optional shift-add multiplier on opcode 9 when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd9;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d, err_q, err_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [SW-1:0]    k;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sh_step;
    logic             sh_c;
    logic             fin, fin_c, fin_v, fin_err;
    logic [WIDTH-1:0] fin_r;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     msum;

    // One partial product per cycle: add multiplicand into the high half, shift right
    assign msum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prod_step = {msum, prod_q[WIDTH-1:1]};
`endif

    assign k            = bus.b[SW-1:0];
    assign bus.in_ready = ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready)) && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;
    assign sum          = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff         = {1'b0, bus.a} - {1'b0, bus.b};

    // One bit of the shift captured at accept
    always_comb begin
        if (op_q == OP_SHL) begin
            sh_step = {work_q[WIDTH-2:0], 1'b0};
            sh_c    = work_q[WIDTH-1];
        end else begin
            sh_step = {1'b0, work_q[WIDTH-1:1]};
            sh_c    = work_q[0];
        end
    end

    // Next state, operation decode and result/flag update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        work_d  = work_q;
        res_d   = res_q;
        z_d     = z_q;
        c_d     = c_q;
        n_d     = n_q;
        v_d     = v_q;
        err_d   = err_q;
        valid_d = valid_q;
`ifdef ALU_SEQ_MUL_EN
        prod_d  = prod_q;
        mcand_d = mcand_q;
`endif
        fin     = 1'b0;
        fin_r   = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        fin_err = 1'b0;

        case (state_q)
            BUSY: begin
                if (cnt_q == '0) begin
                    fin   = 1'b1;
                    fin_r = sh_step;
                    fin_c = sh_c;
`ifdef ALU_SEQ_MUL_EN
                    if (op_q == OP_MUL) begin
                        fin_r = prod_step[WIDTH-1:0];
                        fin_c = |prod_step[2*WIDTH-1:WIDTH];
                    end
`endif
                end else begin
                    cnt_d  = cnt_q - CW'(1);
                    work_d = sh_step;
`ifdef ALU_SEQ_MUL_EN
                    prod_d = prod_step;
`endif
                end
            end
            default: begin
                if ((state_q == HOLD) && bus.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
                if (accept) begin
                    op_d = bus.op;
                    fin  = 1'b1;
                    case (bus.op)
                        OP_ADD: begin
                            fin_r = sum[WIDTH-1:0];
                            fin_c = sum[WIDTH];
                            fin_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            fin_r = diff[WIDTH-1:0];
                            fin_c = diff[WIDTH];
                            fin_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
                        end
                        OP_SHL, OP_SHR: begin
                            if (k == '0) begin
                                fin_r = bus.a;
                            end else begin
                                fin     = 1'b0;
                                work_d  = bus.a;
                                cnt_d   = CW'(k) - CW'(1);
                                state_d = BUSY;
                                valid_d = 1'b0;
                            end
                        end
                        OP_AND:  fin_r = bus.a & bus.b;
                        OP_OR:   fin_r = bus.a | bus.b;
                        OP_XOR:  fin_r = bus.a ^ bus.b;
                        OP_NAND: fin_r = ~(bus.a & bus.b);
                        OP_CMP:  fin_r = {{(WIDTH-3){1'b0}}, bus.a > bus.b, bus.a < bus.b, bus.a == bus.b};
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            fin     = 1'b0;
                            prod_d  = {{WIDTH{1'b0}}, bus.b};
                            mcand_d = bus.a;
                            cnt_d   = CW'(WIDTH - 1);
                            state_d = BUSY;
                            valid_d = 1'b0;
                        end
`endif
                        default: fin_err = 1'b1;
                    endcase
                end
            end
        endcase

        if (fin) begin
            state_d = HOLD;
            valid_d = 1'b1;
            res_d   = fin_r;
            z_d     = !fin_err && (fin_r == '0);
            c_d     = fin_c;
            n_d     = fin_r[WIDTH-1];
            v_d     = fin_v;
            err_d   = fin_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            work_q  <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
            mcand_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            work_q  <= work_d;
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
            v_q     <= v_d;
            err_q   <= err_d;
            valid_q <= valid_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
`endif
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_result = res_q;
    assign bus.flag_z     = z_q;
    assign bus.flag_c     = c_q;
    assign bus.flag_n     = n_q;
    assign bus.flag_v     = v_q;
    assign bus.flag_err   = err_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU; next-generation replacement for the 8-bit combinational ALU. It exposes one opcode-selected result instead of parallel outputs, registers results and status flags, and executes variable-amount shifts iteratively, one bit per cycle. It sits between the register file read ports and the writeback stage. Valid/ready handshakes on both sides let the control unit stall on multi-cycle operations.

## Interface
- WIDTH, 8, operand/result width; power of 2, ≥ 4; shift amount field SW = $clog2(WIDTH)
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset; synchronous, active-low
- IN_VALID  in  1  operation request
- IN_READY  out  1  block can accept a request this cycle
- OP  in  4  opcode (see Operation)
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; shifts use B[SW-1:0] as amount
- OUT_VALID  out  1  OUT_RESULT/flags valid
- OUT_READY  in  1  consumer takes result this cycle
- OUT_RESULT  out  WIDTH  result
- FLAG_Z / FLAG_C / FLAG_N / FLAG_V / FLAG_ERR  out  1 each  zero, carry, negative, signed overflow, illegal opcode

## Operation
- Opcodes:
  - 0 ADD A+B; C = carry out; V = signed overflow.
  - 1 SUB A−B; C = borrow (A<B unsigned); V = signed overflow.
  - 2 SHL by k; C = last bit shifted out; 0 if k=0.
  - 3 SHR logical by k; C = last bit shifted out; 0 if k=0.
  - 4 AND, 5 OR, 6 XOR, 7 NAND.
  - 8 CMP: result bit0 = A==B, bit1 = A<B, bit2 = A>B (unsigned), other bits 0.
  - 9 MUL (macro only, see Configuration).
  - Any other opcode: result 0, ERR = 1.
- Flags:
  - Z = (result==0) for all legal opcodes.
  - N = result MSB.
  - C and V are 0 for any opcode not listed above as setting them.
- Operands and OP are captured at accept. Later input changes do not affect an operation in flight.
- FSM states:
  - IDLE: no result held.
  - BUSY: iterating a shift or MUL; holds a down-counter.
  - HOLD: OUT_VALID = 1.
- Accept = IN_VALID & IN_READY.
- IN_READY = (IDLE | (HOLD & OUT_READY)) & RST_N.
- Transitions:
  - IDLE/HOLD on accept of a single-cycle op, SHL/SHR with k=0, or an illegal op → HOLD with the new result.
  - IDLE/HOLD on accept of a shift with k>0 or MUL → BUSY.
  - BUSY → HOLD when the counter expires.
  - HOLD & OUT_READY & no accept → IDLE.
- Simultaneous drain and accept in HOLD is legal and gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- Shift wrap-around: amount is B mod WIDTH; B = WIDTH+1 shifts by 1.

## Timing
- Reset values (RST_N low at an edge):
  - State IDLE; OUT_VALID 0; OUT_RESULT 0; all flags 0; counter 0.
  - IN_READY is 0 while RST_N is low.
- Reset mid-operation (BUSY or HOLD) aborts. No OUT_VALID pulse is produced and the result is discarded.
- Latency:
  - Single-cycle op accepted at edge t: OUT_VALID high from edge t+1.
  - Shift by k>0: OUT_VALID from edge t+k+1.
  - MUL: OUT_VALID from edge t+WIDTH+1.
- During BUSY: IN_READY = 0 and OUT_VALID = 0.
- OUT_RESULT and flags are stable while OUT_VALID & !OUT_READY.
- OUT_VALID never drops without OUT_READY, except on reset.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - Opcode 9 is an unsigned shift-add multiply, one partial product per cycle, WIDTH cycles in BUSY.
  - OUT_RESULT = low WIDTH bits; C = 1 if the high half is non-zero; V = 0.
- ALU_SEQ_MUL_EN undefined:
  - Opcode 9 is illegal (single-cycle, result 0, ERR = 1).
  - No multiplier datapath is synthesised.

## Test plan
- WIDTH=8, ADD A=0xF0 B=0x20 → OUT_RESULT 0x10, C=1, V=0, Z=0, OUT_VALID one cycle after accept. SUB A=0x80 B=0x01 → 0x7F, V=1, C=0.
- Back-to-back with OUT_READY=1: ADD, XOR 0xAA^0xAA, CMP 0x05 vs 0x09 on consecutive cycles → results 0x.., 0x00 (Z=1), 0x02 on consecutive cycles; IN_READY never drops.
- SHL A=0x81 B=0x03 → 0x08, C=0, OUT_VALID 4 cycles after accept, IN_READY low for 3 cycles. SHR A=0x81 B=0x09 (wraps to 1) → 0x40, C=1, latency 2.
- Backpressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1 → result and flags stable, no second accept. Raise OUT_READY → drain and accept in the same cycle.
- Reset: SHL B=7 accepted, RST_N low 3 cycles later → OUT_VALID 0, OUT_RESULT 0, flags 0. IN_READY=1 the cycle after RST_N returns high. OP=0xF → ERR=1, result 0.
- With ALU_SEQ_MUL_EN: MUL 0x0F×0x11 → 0xFF, C=0; 0x10×0x10 → 0x00, Z=1, C=1; latency 9. Without the macro: OP=9 → ERR=1, latency 1.
